// File: rtl/instr_encoder.sv
// instr_encoder: turns symbolic MIPS instruction fields into 32-bit machine words. It queues
// each word with its target word address in a small FIFO and writes them into instruction
// memory through a req/ack port.
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   load_base, base         set the next enqueue address, flush the FIFO, abort a write in flight
//   in_valid/in_ready       handshake for the instruction fields
//   in_op, in_rs, in_rt,    mnemonic select and register/shift fields
//   in_rd, in_shamt
//   in_imm                  imm16, absolute branch target (word), or J target26
//   mem_we/mem_addr/        memory write request, held stable until mem_ack
//   mem_wdata/mem_ack
//   count                   words written since reset/load_base (saturating)
//   err, err_addr           sticky branch-range error and the address of the first bad branch
module instr_encoder #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_base,
  input  logic [ADDR_W-1:0] base,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [25:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OffW = ADDR_W + 1;

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSlt  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpNor  = 4'd4;
  localparam logic [3:0] OpSub  = 4'd5;
  localparam logic [3:0] OpSll  = 4'd6;
  localparam logic [3:0] OpSrl  = 4'd7;
  localparam logic [3:0] OpAddi = 4'd8;
  localparam logic [3:0] OpAndi = 4'd9;
  localparam logic [3:0] OpOri  = 4'd10;
  localparam logic [3:0] OpLw   = 4'd11;
  localparam logic [3:0] OpSw   = 4'd12;
  localparam logic [3:0] OpBeq  = 4'd13;
  localparam logic [3:0] OpBne  = 4'd14;
  localparam logic [3:0] OpJ    = 4'd15;

  typedef enum logic [0:0] {StIdle, StWrite} state_e;

  state_e              state_q, state_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic [ADDR_W-1:0]   enq_addr_q, enq_addr_d;
  logic [PtrW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic [ADDR_W-1:0]   fifo_addr_q [DEPTH];
  logic [31:0]         fifo_data_q [DEPTH];

  logic [PtrW:0]       occ;
  logic                fifo_full, fifo_empty;
  logic [PtrW-1:0]     head_idx, next_idx, wr_idx;
  logic                push, pop;

  // ---------------------------------------------------------------------------------------------
  // Encode stage
  // ---------------------------------------------------------------------------------------------
  logic [OffW-1:0]     br_off;
  logic signed [31:0]  br_off_ext;
  logic                is_r, is_shift, is_br, is_j, br_oor;
  logic [5:0]          funct, opcode;
  logic [31:0]         enc_word;

  // Branch offset is relative to the word after the branch. The extra bit keeps the difference
  // of two ADDR_W-bit addresses exact before it is range checked.
  assign br_off     = {1'b0, in_imm[ADDR_W-1:0]} - {1'b0, enq_addr_q} - OffW'(1);
  assign br_off_ext = 32'($signed(br_off));

  always_comb begin
    is_r     = 1'b0;
    is_shift = 1'b0;
    is_br    = 1'b0;
    is_j     = 1'b0;
    funct    = 6'h00;
    opcode   = 6'h00;
    case (in_op)
      OpAdd:  begin is_r = 1'b1; funct = 6'h20; end
      OpSlt:  begin is_r = 1'b1; funct = 6'h2a; end
      OpAnd:  begin is_r = 1'b1; funct = 6'h24; end
      OpOr:   begin is_r = 1'b1; funct = 6'h25; end
      OpNor:  begin is_r = 1'b1; funct = 6'h27; end
      OpSub:  begin is_r = 1'b1; funct = 6'h22; end
      OpSll:  begin is_r = 1'b1; is_shift = 1'b1; funct = 6'h00; end
      OpSrl:  begin is_r = 1'b1; is_shift = 1'b1; funct = 6'h02; end
      OpAddi: opcode = 6'h08;
      OpAndi: opcode = 6'h0c;
      OpOri:  opcode = 6'h0d;
      OpLw:   opcode = 6'h23;
      OpSw:   opcode = 6'h2b;
      OpBeq:  begin opcode = 6'h04; is_br = 1'b1; end
      OpBne:  begin opcode = 6'h05; is_br = 1'b1; end
      OpJ:    begin opcode = 6'h02; is_j = 1'b1; end
      default: ;
    endcase

    if (is_j) begin
      enc_word = {opcode, in_imm};
    end else if (is_r) begin
      enc_word = {6'h00, is_shift ? 5'd0 : in_rs, in_rt, in_rd,
                  is_shift ? in_shamt : 5'd0, funct};
    end else if (is_br) begin
      enc_word = {opcode, in_rs, in_rt, br_off_ext[15:0]};
    end else begin
      enc_word = {opcode, in_rs, in_rt, in_imm[15:0]};
    end

    // Unreachable for ADDR_W <= 15 but kept so wider builds still flag bad branches.
    br_oor = is_br && ((br_off_ext > 32'sd32767) || (br_off_ext < -32'sd32768));
  end

  // ---------------------------------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------------------------------
  assign occ        = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = (occ == (PtrW+1)'(DEPTH));
  assign fifo_empty = (occ == '0);
  assign head_idx   = rd_ptr_q[PtrW-1:0];
  assign next_idx   = head_idx + PtrW'(1);
  assign wr_idx     = wr_ptr_q[PtrW-1:0];
  assign in_ready   = !fifo_full;
  assign push       = in_valid && in_ready && !load_base;

  // ---------------------------------------------------------------------------------------------
  // Write FSM and next-state logic
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    count_d     = count_q;
    pop         = 1'b0;
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    enq_addr_d  = enq_addr_q;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          mem_addr_d  = fifo_addr_q[head_idx];
          mem_wdata_d = fifo_data_q[head_idx];
          mem_we_d    = 1'b1;
          state_d     = StWrite;
        end
      end
      StWrite: begin
        if (mem_ack) begin
          pop     = 1'b1;
          count_d = (count_q == '1) ? count_q : count_q + (ADDR_W+1)'(1);
          // Head stays in the FIFO while it is on the bus, so the follower is at head+1.
          if (occ > (PtrW+1)'(1)) begin
            mem_addr_d  = fifo_addr_q[next_idx];
            mem_wdata_d = fifo_data_q[next_idx];
          end else begin
            mem_we_d = 1'b0;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (push) begin
      enq_addr_d = enq_addr_q + ADDR_W'(1);
      if (br_oor) begin
        err_d = 1'b1;
        if (!err_q) err_addr_d = enq_addr_q;
      end
    end

    rd_ptr_d = rd_ptr_q + (PtrW+1)'(pop);
    wr_ptr_d = wr_ptr_q + (PtrW+1)'(push);

    if (load_base) begin
      state_d    = StIdle;
      mem_we_d   = 1'b0;
      count_d    = '0;
      enq_addr_d = base;
      rd_ptr_d   = wr_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_idx] <= enq_addr_q;
      fifo_data_q[wr_idx] <= enc_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
      enq_addr_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      count_q     <= count_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
      enq_addr_q  <= enq_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign err       = err_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default (ADDR_W=10) instance for encoding, FIFO and write
// FSM behaviour, plus an ADDR_W=16 instance for out-of-range branch offsets.
module tb_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-width instance
  logic        reset, load_base, in_valid, in_ready, mem_we, mem_ack, err;
  logic [9:0]  base, mem_addr, err_addr;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [25:0] in_imm;
  logic [31:0] mem_wdata;
  logic [10:0] count;

  // Wide instance
  logic        w_load_base, w_valid, w_ready, w_we, w_ack, w_err;
  logic [15:0] w_base, w_addr, w_err_addr;
  logic [3:0]  w_op;
  logic [4:0]  w_rs, w_rt, w_zero5;
  logic [25:0] w_imm;
  logic [31:0] w_wdata;
  logic [16:0] w_count;

  instr_encoder u_dut (
    .clk(clk), .reset(reset), .load_base(load_base), .base(base),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .count(count), .err(err), .err_addr(err_addr)
  );

  instr_encoder #(.ADDR_W(16), .DEPTH(4)) u_wide (
    .clk(clk), .reset(reset), .load_base(w_load_base), .base(w_base),
    .in_valid(w_valid), .in_ready(w_ready), .in_op(w_op), .in_rs(w_rs), .in_rt(w_rt),
    .in_rd(w_zero5), .in_shamt(w_zero5), .in_imm(w_imm),
    .mem_we(w_we), .mem_addr(w_addr), .mem_wdata(w_wdata), .mem_ack(w_ack),
    .count(w_count), .err(w_err), .err_addr(w_err_addr)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t wq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change 1 time unit after posedge, so a negedge sample sees what the next edge takes.
  always @(negedge clk) begin
    if (mem_we && mem_ack && !reset && !load_base) wq.push_back('{cyc, mem_addr, mem_wdata});
  end

  // Stall-test vectors: LW, SW, SUB (junk shamt), NOR, SRL (junk rs), J
  logic [3:0]  v_op   [6] = '{4'd11, 4'd12, 4'd5, 4'd4, 4'd7, 4'd15};
  logic [4:0]  v_rs   [6] = '{5'd29, 5'd29, 5'd8, 5'd1, 5'd5, 5'd0};
  logic [4:0]  v_rt   [6] = '{5'd8, 5'd9, 5'd9, 5'd2, 5'd4, 5'd0};
  logic [4:0]  v_rd   [6] = '{5'd0, 5'd0, 5'd10, 5'd3, 5'd4, 5'd0};
  logic [4:0]  v_sh   [6] = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd3, 5'd0};
  logic [25:0] v_imm  [6] = '{26'h4, 26'hfffc, 26'h0, 26'h0, 26'h0, 26'h40};
  logic [31:0] v_word [6] = '{32'h8fa80004, 32'hafa9fffc, 32'h01095022,
                              32'h00221827, 32'h000420c2, 32'h08000040};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [4:0] sh, input logic [25:0] imm);
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_imm = imm;
  endtask

  // Present one instruction and hold it until accepted.
  task automatic push(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [25:0] imm);
    int n;
    set_fields(op, rs, rt, rd, sh, imm);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 64) begin
      tick;
      n++;
    end
    if (n == 64) chk("push_ready_timeout", 64'(in_ready), 64'd1);
    tick;
    in_valid = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    int k;
    k = 0;
    while (wq.size() < n && k < 64) begin
      tick;
      k++;
    end
    tick;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded limit 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    logic fire;
    reset = 1'b1; load_base = 1'b0; base = '0; in_valid = 1'b0; mem_ack = 1'b0;
    set_fields(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0);
    w_load_base = 1'b0; w_base = '0; w_valid = 1'b0; w_op = '0; w_rs = '0; w_rt = '0;
    w_imm = '0; w_ack = 1'b0; w_zero5 = '0;
    tick; tick;
    reset = 1'b0;

    // Reset state
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_err_addr", 64'(err_addr), 64'd0);
    chk("rst_w_ready", 64'(w_ready), 64'd1);

    // ADDI rt=16 imm=0xFEFE, with latency
    mem_ack = 1'b1;
    wq.delete();
    push(4'd8, 5'd0, 5'd16, 5'd0, 5'd0, 26'hfefe);
    chk("addi_we_early", 64'(mem_we), 64'd0);
    tick;
    chk("addi_we", 64'(mem_we), 64'd1);
    chk("addi_addr", 64'(mem_addr), 64'd0);
    chk("addi_data", 64'(mem_wdata), 64'h2010fefe);
    tick;
    chk("addi_we_drop", 64'(mem_we), 64'd0);
    chk("addi_count", 64'(count), 64'd1);

    // SLL with junk rs, then AND, back to back
    reset = 1'b1; tick; reset = 1'b0;
    wq.delete();
    push(4'd6, 5'd7, 5'd16, 5'd16, 5'd16, 26'd0);
    push(4'd2, 5'd16, 5'd17, 5'd8, 5'd0, 26'd0);
    wait_writes(2);
    chk("sll_and_nwrites", 64'(wq.size()), 64'd2);
    if (wq.size() >= 2) begin
      chk("sll_addr", 64'(wq[0].addr), 64'd0);
      chk("sll_data", 64'(wq[0].data), 64'h00108400);
      chk("and_addr", 64'(wq[1].addr), 64'd1);
      chk("and_data", 64'(wq[1].data), 64'h02114024);
      chk("and_back_to_back", 64'(wq[1].cyc - wq[0].cyc), 64'd1);
    end

    // load_base 5 with a simultaneous (discarded) push, then BNE to target 2
    wq.delete();
    load_base = 1'b1; base = 10'd5;
    set_fields(4'd0, 5'd1, 5'd1, 5'd1, 5'd0, 26'd0);
    in_valid = 1'b1;
    tick;
    load_base = 1'b0; in_valid = 1'b0;
    chk("lb_count_clear", 64'(count), 64'd0);
    push(4'd14, 5'd9, 5'd0, 5'd0, 5'd0, 26'd2);
    wait_writes(1);
    chk("bne_nwrites", 64'(wq.size()), 64'd1);
    if (wq.size() >= 1) begin
      chk("bne_addr", 64'(wq[0].addr), 64'd5);
      chk("bne_data", 64'(wq[0].data), 64'h1520fffc);
    end
    chk("bne_err", 64'(err), 64'd0);

    // Stall: ack low, fill FIFO, hold a fifth request
    reset = 1'b1; tick; reset = 1'b0;
    mem_ack = 1'b0;
    wq.delete();
    for (int i = 0; i < 4; i++) push(v_op[i], v_rs[i], v_rt[i], v_rd[i], v_sh[i], v_imm[i]);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    set_fields(v_op[4], v_rs[4], v_rt[4], v_rd[4], v_sh[4], v_imm[4]);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_we", 64'(mem_we), 64'd1);
      chk("stall_addr", 64'(mem_addr), 64'd0);
      chk("stall_data", 64'(mem_wdata), 64'h8fa80004);
    end
    mem_ack = 1'b1;
    idx = 4;
    for (int k = 0; k < 60 && wq.size() < 6; k++) begin
      fire = in_valid && in_ready;
      tick;
      if (fire) begin
        idx++;
        if (idx < 6) set_fields(v_op[idx], v_rs[idx], v_rt[idx], v_rd[idx], v_sh[idx], v_imm[idx]);
        else in_valid = 1'b0;
      end
    end
    tick; tick;
    chk("stall_nwrites", 64'(wq.size()), 64'd6);
    for (int i = 0; i < 6 && i < wq.size(); i++) begin
      chk("stall_wr_addr", 64'(wq[i].addr), 64'(i));
      chk("stall_wr_data", 64'(wq[i].data), 64'(v_word[i]));
    end

    // Remaining R-type funct codes and ANDI, continuing at address 6
    wq.delete();
    push(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0);
    push(4'd1, 5'd4, 5'd5, 5'd6, 5'd0, 26'd0);
    push(4'd3, 5'd7, 5'd8, 5'd9, 5'd0, 26'd0);
    push(4'd9, 5'd10, 5'd11, 5'd0, 5'd0, 26'h00ff);
    wait_writes(4);
    chk("mix_nwrites", 64'(wq.size()), 64'd4);
    if (wq.size() >= 4) begin
      chk("add_data", 64'(wq[0].data), 64'h00221820);
      chk("slt_data", 64'(wq[1].data), 64'h0085302a);
      chk("or_data", 64'(wq[2].data), 64'h00e84825);
      chk("andi_data", 64'(wq[3].data), 64'h314b00ff);
      chk("add_addr", 64'(wq[0].addr), 64'd6);
      chk("andi_addr", 64'(wq[3].addr), 64'd9);
    end
    chk("mix_count", 64'(count), 64'd10);

    // Wide build: out-of-range branches
    w_ack = 1'b1;
    w_load_base = 1'b1; w_base = 16'd0;
    tick;
    w_load_base = 1'b0;
    w_op = 4'd13; w_rs = 5'd1; w_rt = 5'd2; w_imm = 26'hffff;
    w_valid = 1'b1;
    tick;
    w_valid = 1'b0;
    chk("wide_err", 64'(w_err), 64'd1);
    chk("wide_err_addr", 64'(w_err_addr), 64'd0);
    tick;
    chk("wide_beq_we", 64'(w_we), 64'd1);
    chk("wide_beq_addr", 64'(w_addr), 64'd0);
    chk("wide_beq_data", 64'(w_wdata), 64'h1022fffe);
    w_op = 4'd14;
    w_valid = 1'b1;
    tick;
    w_valid = 1'b0;
    chk("wide_err2", 64'(w_err), 64'd1);
    chk("wide_err_addr2", 64'(w_err_addr), 64'd0);
    for (int k = 0; k < 10 && !(w_we && w_addr == 16'd1); k++) tick;
    chk("wide_bne_we", 64'(w_we), 64'd1);
    chk("wide_bne_data", 64'(w_wdata), 64'h1422fffd);

    // load_base alone during a stall, then reset with load_base during a stall
    mem_ack = 1'b0;
    wq.delete();
    load_base = 1'b1; base = 10'd3;
    tick;
    load_base = 1'b0;
    chk("lb2_count", 64'(count), 64'd0);
    chk("lb2_we", 64'(mem_we), 64'd0);
    push(4'd10, 5'd1, 5'd2, 5'd0, 5'd0, 26'h1234);
    push(4'd10, 5'd1, 5'd2, 5'd0, 5'd0, 26'h5678);
    chk("ori_we", 64'(mem_we), 64'd1);
    chk("ori_addr", 64'(mem_addr), 64'd3);
    chk("ori_data", 64'(mem_wdata), 64'h34221234);
    tick;
    reset = 1'b1; load_base = 1'b1;
    tick;
    reset = 1'b0; load_base = 1'b0;
    chk("abort_we", 64'(mem_we), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_count", 64'(count), 64'd0);
    chk("abort_addr", 64'(mem_addr), 64'd0);
    mem_ack = 1'b1;
    tick; tick; tick; tick;
    chk("abort_no_retry", 64'(wq.size()), 64'd0);
    chk("abort_we_idle", 64'(mem_we), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
